time_keeper_bcd: RTL

Consumes the ~1 s square wave produced by the LCD-clock divider and keeps wall-clock time as BCD digits (HH:MM:SS) for the LCD formatter. Each transition of the divider output is one second. The block also provides a two-button set mode for hours and minutes. It runs entirely in the 50 MHz system clock domain. All external inputs are synchronised internally, and digit changes are flagged to the display writer with a one-cycle pulse.

---
 rtl/time_keeper_bcd.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/time_keeper_bcd.sv
// time_keeper_bcd: BCD wall-clock (HH:MM:SS) driven by a ~1 s square wave,
// with a two-button set mode for hours and minutes.
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   sec_toggle        divider square wave, each edge is one second (async)
//   btn_mode, btn_inc debounced button levels (async), rising edge = event
//   hh_t..ss_u        BCD digit registers
//   mode              0=RUN, 1=SET_HH, 2=SET_MM
//   update            one-cycle pulse whenever any digit register is written
module time_keeper_bcd #(
  parameter bit FMT24 = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_toggle,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [1:0] hh_t,
  output logic [3:0] hh_u,
  output logic [2:0] mm_t,
  output logic [3:0] mm_u,
  output logic [2:0] ss_t,
  output logic [3:0] ss_u,
  output logic [1:0] mode,
  output logic       update
);

  localparam logic [1:0] HH_T_RST = FMT24 ? 2'd0 : 2'd1;
  localparam logic [3:0] HH_U_RST = FMT24 ? 4'd0 : 4'd2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2
  } mode_e;

  mode_e state_q, state_d;

  // [0]=s1, [1]=s2, [2]=s3 (history)
  logic [2:0] sec_sr, mode_sr, inc_sr;
  logic       tick, mode_ev, inc_ev;

  logic [1:0] hh_t_d;
  logic [3:0] hh_u_d;
  logic [2:0] mm_t_d;
  logic [3:0] mm_u_d;
  logic [2:0] ss_t_d;
  logic [3:0] ss_u_d;
  logic       update_d;

  logic [7:0] ss_nx, mm_nx;
  logic [5:0] hh_nx;

  // Minute/second increment: returns {carry, tens, units}
  function automatic logic [7:0] inc59(input logic [2:0] t, input logic [3:0] u);
    if (t == 3'd5 && u == 4'd9) return {1'b1, 3'd0, 4'd0};
    else if (u == 4'd9)         return {1'b0, 3'(t + 3'd1), 4'd0};
    else                        return {1'b0, t, 4'(u + 4'd1)};
  endfunction

  // Hour increment with the range limit of the selected format
  function automatic logic [5:0] inc_hh(input logic [1:0] t, input logic [3:0] u);
    if (FMT24 && t == 2'd2 && u == 4'd3)  return {2'd0, 4'd0};
    else if (!FMT24 && t == 2'd1 && u == 4'd2) return {2'd0, 4'd1};
    else if (u == 4'd9)                   return {2'(t + 2'd1), 4'd0};
    else                                  return {t, 4'(u + 4'd1)};
  endfunction

  assign ss_nx = inc59(ss_t, ss_u);
  assign mm_nx = inc59(mm_t, mm_u);
  assign hh_nx = inc_hh(hh_t, hh_u);

  assign tick    = sec_sr[1] ^ sec_sr[2];
  assign mode_ev = mode_sr[1] & ~mode_sr[2];
  assign inc_ev  = inc_sr[1] & ~inc_sr[2];
  assign mode    = state_q;

  // Synchronisers plus history flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_sr  <= 3'd0;
      mode_sr <= 3'd0;
      inc_sr  <= 3'd0;
    end else begin
      sec_sr  <= {sec_sr[1:0], sec_toggle};
      mode_sr <= {mode_sr[1:0], btn_mode};
      inc_sr  <= {inc_sr[1:0], btn_inc};
    end
  end

  // State, digit and update registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      hh_t    <= HH_T_RST;
      hh_u    <= HH_U_RST;
      mm_t    <= 3'd0;
      mm_u    <= 4'd0;
      ss_t    <= 3'd0;
      ss_u    <= 4'd0;
      update  <= 1'b0;
    end else begin
      state_q <= state_d;
      hh_t    <= hh_t_d;
      hh_u    <= hh_u_d;
      mm_t    <= mm_t_d;
      mm_u    <= mm_u_d;
      ss_t    <= ss_t_d;
      ss_u    <= ss_u_d;
      update  <= update_d;
    end
  end

  // Next-state and digit update; mode step takes priority over inc
  always_comb begin
    state_d  = state_q;
    hh_t_d   = hh_t;
    hh_u_d   = hh_u;
    mm_t_d   = mm_t;
    mm_u_d   = mm_u;
    ss_t_d   = ss_t;
    ss_u_d   = ss_u;
    update_d = 1'b0;
    case (state_q)
      RUN: begin
        if (tick) begin
          {ss_t_d, ss_u_d} = ss_nx[6:0];
          if (ss_nx[7]) begin
            {mm_t_d, mm_u_d} = mm_nx[6:0];
            if (mm_nx[7]) {hh_t_d, hh_u_d} = hh_nx;
          end
          update_d = 1'b1;
        end
        // A coincident tick still carries; only the seconds are cleared
        if (mode_ev) begin
          state_d  = SET_HH;
          ss_t_d   = 3'd0;
          ss_u_d   = 4'd0;
          update_d = 1'b1;
        end
      end
      SET_HH: begin
        if (mode_ev) begin
          state_d = SET_MM;
        end else if (inc_ev) begin
          {hh_t_d, hh_u_d} = hh_nx;
          update_d = 1'b1;
        end
      end
      SET_MM: begin
        if (mode_ev) begin
          state_d = RUN;
        end else if (inc_ev) begin
          {mm_t_d, mm_u_d} = mm_nx[6:0];
          update_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

endmodule
